// File: rtl/fp_pkg.sv
// Shared FP definitions: exception flag layout and reciprocal pipeline latency.
package fp_pkg;

   typedef struct packed {
      logic invalid;
      logic div_by_zero;
      logic overflow;
      logic underflow;
      logic inexact;
   } fp_flags_t;

   localparam int unsigned FP_RECIP_PIPE_LAT = 13;

endpackage

// File: rtl/fp_result_fifo.sv
// First-word-fall-through result FIFO; a write while full is only taken
// when a pop frees the head slot in the same cycle.
module fp_result_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 41
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             wr_ok, rd_ok;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign rd_ok     = rd_en_i & ~empty_o;
   assign wr_ok     = wr_en_i & (~full_o | rd_ok);
   assign rd_data_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(wr_ok);
      rd_ptr_d = rd_ptr_q + AW'(rd_ok);
      count_d  = count_q;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/fp_recip_flow_ctrl.sv
// Credit-based flow control around the FP32 reciprocal pipeline with an in-order result FIFO.
// Optional flag accumulation enabled by defining FP_RECIP_FFLAGS_EN.
module fp_recip_flow_ctrl
   import fp_pkg::*;
#(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned PIPE_LAT = FP_RECIP_PIPE_LAT,
   parameter int unsigned TAG_W    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_data,
   input  logic [2:0]              in_rm,
   input  logic [TAG_W-1:0]        in_tag,
   output logic                    rp_valid_in,
   output logic [31:0]             rp_in,
   output logic [2:0]              rp_rm,
   input  logic                    rp_valid_out,
   input  logic [31:0]             rp_out,
   input  logic [4:0]              rp_flags,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_data,
   output logic [4:0]              out_flags,
   output logic [TAG_W-1:0]        out_tag,
   output logic [$clog2(DEPTH):0]  occupancy,
   output logic                    proto_err,
   input  logic                    fflags_clr,
   output logic [4:0]              fflags
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned PW = 32 + 5 + TAG_W;
   localparam logic [CW-1:0] FULL_CRED = CW'(DEPTH);

   logic [CW-1:0]    credits_q, credits_d;
   logic             accept, pop;
   logic [PIPE_LAT-1:0] tv_q;
   logic [TAG_W-1:0] tt_q [PIPE_LAT];
   logic             last_vld;
   logic             fifo_empty, fifo_full;
   logic [PW-1:0]    fifo_rd;
   fp_flags_t        head_flags;
   logic             proto_err_q, proto_err_d;

   assign in_ready    = (credits_q != '0);
   assign accept      = in_valid & in_ready;
   assign pop         = out_valid & out_ready;
   assign rp_valid_in = accept;
   assign rp_in       = in_data;
   assign rp_rm       = in_rm;
   assign occupancy   = FULL_CRED - credits_q;

   // Credits saturate at DEPTH so a stray pop after an injected result cannot wrap occupancy.
   always_comb begin
      credits_d = credits_q;
      if (accept && !pop)
         credits_d = credits_q - CW'(1);
      else if (pop && !accept && credits_q != FULL_CRED)
         credits_d = credits_q + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credits_q <= FULL_CRED;
         tv_q      <= '0;
         for (int unsigned i = 0; i < PIPE_LAT; i++) tt_q[i] <= '0;
      end else begin
         credits_q <= credits_d;
         tv_q[0]   <= accept;
         tt_q[0]   <= in_tag;
         for (int unsigned i = 1; i < PIPE_LAT; i++) begin
            tv_q[i] <= tv_q[i-1];
            tt_q[i] <= tt_q[i-1];
         end
      end
   end

   assign last_vld = tv_q[PIPE_LAT-1];

   fp_result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (PW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (rp_valid_out),
      .wr_data_i ({rp_out, rp_flags, tt_q[PIPE_LAT-1]}),
      .rd_en_i   (out_ready),
      .rd_data_o (fifo_rd),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full)
   );

   assign out_valid  = ~fifo_empty;
   assign out_data   = fifo_rd[PW-1 -: 32];
   assign head_flags = fp_flags_t'(fifo_rd[TAG_W +: 5]);
   assign out_flags  = head_flags;
   assign out_tag    = fifo_rd[TAG_W-1:0];

   always_comb begin
      proto_err_d = proto_err_q;
      if ((rp_valid_out && !last_vld) || (last_vld && !rp_valid_out) ||
          (rp_valid_out && fifo_full && !pop))
         proto_err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) proto_err_q <= 1'b0;
      else     proto_err_q <= proto_err_d;
   end

   assign proto_err = proto_err_q;

`ifdef FP_RECIP_FFLAGS_EN
   fp_flags_t fflags_q, fflags_d;

   // Clear is applied before the OR so a same-cycle pop survives the clear.
   always_comb begin
      fflags_d = fflags_q;
      if (fflags_clr) fflags_d = '0;
      if (pop)        fflags_d = fp_flags_t'(fflags_d | head_flags);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fflags_q <= '0;
      else     fflags_q <= fflags_d;
   end

   assign fflags = fflags_q;
`else
   // Clear input has no effect here; masking keeps it referenced.
   assign fflags = {5{fflags_clr}} & 5'b0;
`endif

endmodule
